axil_master: RTL
================

# axil_master

AXI4-Lite initiator that turns single-beat register commands from local logic into AXI4-Lite write or read transactions. It is the master-side counterpart of the team's AXI4-Lite register slaves, such as the packet_size/pp_group/frame_size block. It lets on-chip sequencers program and poll those slaves without a processor. One transaction is in flight at a time, and the block returns exactly one response per accepted command.

## Interface
- AW, 8: address width in bits; matches the slave AW.
- TIMEOUT_CYCLES, 1024: cycles allowed from command accept to response handshake. Range 2..65535.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE and only while reset is low.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  byte address; passed to the bus unmodified.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  write strobes.
- rsp_valid  out  1  one-cycle pulse; no backpressure.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  OKAY=0, SLVERR=2, DECERR=3, as returned by the slave.
- rsp_timeout  out  1  qualifies rsp_valid; transaction abandoned.
- M_AXI_AWADDR/AWVALID/AWREADY/AWPROT, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARVALID/ARREADY/ARPROT, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master ports, AW-bit addresses, 32-bit data. AWPROT and ARPROT are tied to 3'b000.

## Operation
- All outputs are registered. Reset values: every *VALID, BREADY, RREADY, rsp_valid and rsp_timeout = 0; rsp_rdata = 0; rsp_resp = 0. cmd_ready reads 0 during reset.
- States:
  - IDLE -> WR on an accepted command with cmd_write=1; IDLE -> RD_A on an accepted command with cmd_write=0.
  - WR: AWVALID and WVALID rise together. Each drops the cycle after its own handshake, independently of the other; AW and W may complete in either order or the same cycle. Go to WR_B when both are done.
  - WR_B: BREADY=1. On the BVALID handshake, latch BRESP and go to RSP.
  - RD_A: ARVALID=1. On the ARREADY handshake, go to RD_R.
  - RD_R: RREADY=1. On the RVALID handshake, latch RDATA and RRESP and go to RSP.
  - RSP: rsp_valid=1 for one cycle, then IDLE.
- Address, data and strobes are captured at cmd accept and held stable until their handshakes. The block never drops a VALID before its READY.
- Reset mid-transaction: all VALIDs and READYs drop on the next edge, no response is issued, and the state returns to IDLE. Recovering the slave is the system's responsibility.

## Timing
- A command is accepted on the cycle where cmd_valid && cmd_ready. Bus VALIDs appear on the next cycle.
- Zero-wait slave: write AW/W handshake at +1, B at +2, rsp_valid at +3. Read AR at +1, R at +2, rsp_valid at +3.
- Back-to-back: cmd_ready returns the cycle after rsp_valid, so the minimum command period is 4 cycles.
- BREADY and RREADY are asserted only in WR_B and RD_R. A BVALID or RVALID present on the entry cycle is handshaken on that cycle.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined:
  - A 16-bit counter clears at cmd accept and increments each busy cycle.
  - If it reaches TIMEOUT_CYCLES before the final B or R handshake, the block issues rsp_valid with rsp_timeout=1 and rsp_resp=SLVERR, then enters DRAIN.
  - DRAIN: keeps outstanding VALIDs until their handshakes, holds BREADY/RREADY=1, silently consumes the late response, then returns to IDLE. cmd_ready stays 0 throughout DRAIN.
  - A response handshake in the same cycle the count hits the limit wins: normal response, no timeout.
- Not defined: no counter and no DRAIN state; rsp_timeout is tied to 0; a stalled slave hangs the block indefinitely.

## Structure
- Shared include axil_defs.vh holds: OKAY/SLVERR/DECERR localparams and the FSM state encodings. The slave side uses the same response codes.
- Optional sub-module axil_timer: load/enable/expire counter, instantiated only under AXIL_MASTER_TIMEOUT_EN.

## Test plan
- Write 0x0000_0040 to addr 0x00 with a zero-wait slave -> single AW/W handshake at +1, rsp_valid at +3, rsp_resp=0, slave packet_size=0x40.
- Write addr 0x04 with AWREADY delayed 5 cycles and WREADY immediate -> WVALID drops at +2, AWVALID holds until its handshake, one rsp_valid.
- Write 0x40 to 0x00 and 0x10 to 0x04, then read 0x08 -> rsp_rdata=0x50, OKAY. Read 0x0C -> rsp_resp=3 (DECERR).
- Read with RVALID withheld for 2000 cycles and the macro enabled -> rsp_timeout=1 and rsp_resp=2 at accept+1024. Late R is drained; cmd_ready stays 0 until the drain completes.
- Assert reset while in WR_B -> next cycle all VALIDs=0, no rsp_valid. A new command is then accepted normally.

Source files
------------

// File: rtl/axil_master_pkg.sv
// Shared AXI4-Lite definitions for axil_master: response codes (same encoding as the register slaves)
// and the initiator FSM state encoding.
package axil_master_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WR    = 3'd1,
      ST_WR_B  = 3'd2,
      ST_RD_A  = 3'd3,
      ST_RD_R  = 3'd4,
      ST_RSP   = 3'd5,
      ST_DRAIN = 3'd6
   } state_t;

endpackage

// File: rtl/axil_master_timer.sv
// Busy-cycle watchdog: clears on load, counts while enabled, flags expiry when the count equals LIMIT.
module axil_master_timer #(
   parameter logic [15:0] LIMIT = 16'd1022
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_load,
   input  logic i_en,
   output logic o_expire
);

   logic [15:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_load) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign o_expire = i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/axil_master.sv
// AXI4-Lite initiator: one local register command -> one AXI4-Lite write/read -> one response pulse.
// Optional watchdog with response drain is built when AXIL_MASTER_TIMEOUT_EN is defined.
module axil_master
   import axil_master_pkg::*;
#(
   parameter int AW             = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_write,
   input  logic [AW-1:0] i_cmd_addr,
   input  logic [31:0]   i_cmd_wdata,
   input  logic [3:0]    i_cmd_wstrb,
   output logic          o_rsp_valid,
   output logic [31:0]   o_rsp_rdata,
   output logic [1:0]    o_rsp_resp,
   output logic          o_rsp_timeout,
   output logic [AW-1:0] o_m_axi_awaddr,
   output logic          o_m_axi_awvalid,
   input  logic          i_m_axi_awready,
   output logic [2:0]    o_m_axi_awprot,
   output logic [31:0]   o_m_axi_wdata,
   output logic [3:0]    o_m_axi_wstrb,
   output logic          o_m_axi_wvalid,
   input  logic          i_m_axi_wready,
   input  logic [1:0]    i_m_axi_bresp,
   input  logic          i_m_axi_bvalid,
   output logic          o_m_axi_bready,
   output logic [AW-1:0] o_m_axi_araddr,
   output logic          o_m_axi_arvalid,
   input  logic          i_m_axi_arready,
   output logic [2:0]    o_m_axi_arprot,
   input  logic [31:0]   i_m_axi_rdata,
   input  logic [1:0]    i_m_axi_rresp,
   input  logic          i_m_axi_rvalid,
   output logic          o_m_axi_rready
);

   state_t        r_state, w_nxt;
   logic [AW-1:0] r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_wstrb;
   logic          r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready, r_rsp_valid;
   logic [31:0]   r_rsp_rdata;
   logic [1:0]    r_rsp_resp;
   logic          w_awvalid, w_wvalid, w_arvalid, w_bready, w_rready, w_rsp_valid;
   logic [31:0]   w_rsp_rdata;
   logic [1:0]    w_rsp_resp;
   logic          w_accept, w_aw_done, w_w_done;

   assign o_cmd_ready = (r_state == ST_IDLE) && !i_reset;
   assign w_accept    = i_cmd_valid && o_cmd_ready;
   // A channel counts as done once its VALID is already low or completes this cycle.
   assign w_aw_done   = !r_awvalid || i_m_axi_awready;
   assign w_w_done    = !r_wvalid  || i_m_axi_wready;

`ifdef AXIL_MASTER_TIMEOUT_EN
   // Expiry on the last busy cycle puts the timeout response exactly TIMEOUT_CYCLES after accept.
   localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES - 2);
   logic w_busy, w_expire, r_rsp_timeout, w_rsp_timeout;

   assign w_busy = r_state inside {ST_WR, ST_WR_B, ST_RD_A, ST_RD_R};

   axil_master_timer #(.LIMIT(TO_LIMIT)) u_timer (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_load   (w_accept),
      .i_en     (w_busy),
      .o_expire (w_expire)
   );
`endif

   always_comb begin
      w_nxt       = r_state;
      w_awvalid   = r_awvalid;
      w_wvalid    = r_wvalid;
      w_arvalid   = r_arvalid;
      w_bready    = r_bready;
      w_rready    = r_rready;
      w_rsp_valid = 1'b0;
      w_rsp_rdata = r_rsp_rdata;
      w_rsp_resp  = r_rsp_resp;
`ifdef AXIL_MASTER_TIMEOUT_EN
      w_rsp_timeout = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (i_cmd_write) begin
                  w_nxt     = ST_WR;
                  w_awvalid = 1'b1;
                  w_wvalid  = 1'b1;
               end else begin
                  w_nxt     = ST_RD_A;
                  w_arvalid = 1'b1;
               end
            end
         end
         ST_WR: begin
            if (i_m_axi_awready) w_awvalid = 1'b0;
            if (i_m_axi_wready)  w_wvalid  = 1'b0;
            if (w_aw_done && w_w_done) begin
               w_nxt    = ST_WR_B;
               w_bready = 1'b1;
            end
         end
         ST_WR_B: begin
            if (i_m_axi_bvalid) begin
               w_nxt       = ST_RSP;
               w_bready    = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_rdata = '0;
               w_rsp_resp  = i_m_axi_bresp;
            end
         end
         ST_RD_A: begin
            if (i_m_axi_arready) begin
               w_nxt     = ST_RD_R;
               w_arvalid = 1'b0;
               w_rready  = 1'b1;
            end
         end
         ST_RD_R: begin
            if (i_m_axi_rvalid) begin
               w_nxt       = ST_RSP;
               w_rready    = 1'b0;
               w_rsp_valid = 1'b1;
               w_rsp_rdata = i_m_axi_rdata;
               w_rsp_resp  = i_m_axi_rresp;
            end
         end
         ST_RSP: w_nxt = ST_IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
         ST_DRAIN: begin
            if (i_m_axi_awready) w_awvalid = 1'b0;
            if (i_m_axi_wready)  w_wvalid  = 1'b0;
            if (i_m_axi_arready) w_arvalid = 1'b0;
            if (i_m_axi_bvalid)  w_bready  = 1'b0;
            if (i_m_axi_rvalid)  w_rready  = 1'b0;
            if (!(w_awvalid || w_wvalid || w_arvalid || w_bready || w_rready)) w_nxt = ST_IDLE;
         end
`endif
         default: w_nxt = ST_IDLE;
      endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
      // A final response handshake in the expiry cycle already steered w_nxt to RSP and wins.
      if (w_expire && (w_nxt != ST_RSP)) begin
         w_nxt         = ST_DRAIN;
         w_rsp_valid   = 1'b1;
         w_rsp_timeout = 1'b1;
         w_rsp_rdata   = '0;
         w_rsp_resp    = RESP_SLVERR;
         w_bready      = (r_state == ST_WR)   || (r_state == ST_WR_B);
         w_rready      = (r_state == ST_RD_A) || (r_state == ST_RD_R);
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_IDLE;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_bready    <= 1'b0;
         r_rready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_resp  <= RESP_OKAY;
      end else begin
         r_state     <= w_nxt;
         r_awvalid   <= w_awvalid;
         r_wvalid    <= w_wvalid;
         r_arvalid   <= w_arvalid;
         r_bready    <= w_bready;
         r_rready    <= w_rready;
         r_rsp_valid <= w_rsp_valid;
         r_rsp_rdata <= w_rsp_rdata;
         r_rsp_resp  <= w_rsp_resp;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
      end else if (w_accept) begin
         r_addr  <= i_cmd_addr;
         r_wdata <= i_cmd_wdata;
         r_wstrb <= i_cmd_wstrb;
      end
   end

`ifdef AXIL_MASTER_TIMEOUT_EN
   always_ff @(posedge i_clk) begin
      if (i_reset) r_rsp_timeout <= 1'b0;
      else         r_rsp_timeout <= w_rsp_timeout;
   end
   assign o_rsp_timeout = r_rsp_timeout;
`else
   assign o_rsp_timeout = 1'b0;
`endif

   assign o_rsp_valid     = r_rsp_valid;
   assign o_rsp_rdata     = r_rsp_rdata;
   assign o_rsp_resp      = r_rsp_resp;
   assign o_m_axi_awaddr  = r_addr;
   assign o_m_axi_araddr  = r_addr;
   assign o_m_axi_wdata   = r_wdata;
   assign o_m_axi_wstrb   = r_wstrb;
   assign o_m_axi_awvalid = r_awvalid;
   assign o_m_axi_wvalid  = r_wvalid;
   assign o_m_axi_arvalid = r_arvalid;
   assign o_m_axi_bready  = r_bready;
   assign o_m_axi_rready  = r_rready;
   assign o_m_axi_awprot  = 3'b000;
   assign o_m_axi_arprot  = 3'b000;

endmodule
